// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Multiplexed 7-segment display controller for NDIG common-anode digits.
//   VALUE/DOTS are latched into a shadow register through a LOAD/BUSY
//   handshake. Digits are scanned most-significant first, one slot of
//   2^PRESC_LOG2 clocks each, with PWM brightness, leading-zero blanking,
//   blank-before-switch and a frame strobe.
//
//   Optional feature macro: SEG7_BIN2BCD_EN
//     undefined : VALUE is NDIG hex nibbles, captured the cycle after LOAD,
//                 BUSY tied low.
//     defined   : VALUE is unsigned binary, converted to BCD by a
//                 double-dabble FSM (IDLE->CONV->DONE); values >= 10^NDIG
//                 display a dash on every digit.
//
// Ports
//   CLK       in   system clock, posedge
//   RST_N     in   asynchronous active-low reset
//   VALUE     in   [4*NDIG-1:0] value to display
//   DOTS      in   [NDIG-1:0]   decimal points, 1 = lit
//   LOAD      in   capture VALUE/DOTS when BUSY=0
//   BUSY      out  1 = LOAD ignored
//   BLANK_LZ  in   1 = blank leading zero digits (sampled live)
//   BRIGHT    in   [BRIGHT_W-1:0] PWM brightness, all-ones = 100%
//   SEG       out  [6:0] segments g..a, active-low
//   DP        out  decimal point, active-low
//   DIG_SEL   out  [NDIG-1:0] digit enable, active-high, one-hot or zero
//   FRAME     out  1-cycle pulse when the scan wraps to digit NDIG-1
module seg7_scan_ctrl #(
    parameter int unsigned NDIG       = 4,
    parameter int unsigned PRESC_LOG2 = 12,
    parameter int unsigned BRIGHT_W   = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [4*NDIG-1:0]     VALUE,
    input  logic [NDIG-1:0]       DOTS,
    input  logic                  LOAD,
    output logic                  BUSY,
    input  logic                  BLANK_LZ,
    input  logic [BRIGHT_W-1:0]   BRIGHT,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic [NDIG-1:0]       DIG_SEL,
    output logic                  FRAME
);

    localparam int unsigned VW    = 4 * NDIG;
    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NDIG - 1);

    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Scan and display state
    logic [PRESC_LOG2-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VW-1:0]         shadow_q, shadow_d;
    logic [NDIG-1:0]       dots_q, dots_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NDIG-1:0]       dig_sel_q, dig_sel_d;
    logic                  frame_q, frame_d;

    logic                  slot_end;
    logic [BRIGHT_W-1:0]   phase;
    logic                  dig_en;
    logic                  seen_nz;
    logic [NDIG-1:0]       lead_zero;
    logic [3:0]            cur_nib;
    logic                  cur_dot;
    logic                  cur_lz;
    logic                  blank;
    logic                  ovf_show;

    always_comb begin
        presc_d  = presc_q + PRESC_LOG2'(1);
        slot_end = &presc_q;
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == '0) ? IDX_TOP : idx_q - IDX_W'(1);
        end
        frame_d = slot_end && (idx_q == '0);

        // Last cycle of every slot is dark so the next digit never ghosts.
        phase  = presc_q[PRESC_LOG2-1 -: BRIGHT_W];
        dig_en = ((&BRIGHT) || (phase < BRIGHT)) && !slot_end;

        // lead_zero[k]: digits NDIG-1 down to k are all zero
        seen_nz   = 1'b0;
        lead_zero = '0;
        for (int unsigned k = NDIG; k > 0; k--) begin
            seen_nz        = seen_nz | (shadow_q[4*(k-1) +: 4] != 4'h0);
            lead_zero[k-1] = ~seen_nz;
        end

        cur_nib   = '0;
        cur_dot   = 1'b0;
        cur_lz    = 1'b0;
        dig_sel_d = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib      = shadow_q[4*k +: 4];
                cur_dot      = dots_q[k];
                cur_lz       = lead_zero[k];
                dig_sel_d[k] = dig_en;
            end
        end

        blank = BLANK_LZ && cur_lz && (idx_q != '0);
        seg_d = blank ? 7'h7F : font(cur_nib);
        if (ovf_show) begin
            seg_d = 7'h3F;
        end
        dp_d = ~cur_dot;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_q   <= '0;
            idx_q     <= IDX_TOP;
            shadow_q  <= '0;
            dots_q    <= '0;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
            dig_sel_q <= '0;
            frame_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            dots_q    <= dots_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            dig_sel_q <= dig_sel_d;
            frame_q   <= frame_d;
        end
    end

    assign SEG     = seg_q;
    assign DP      = dp_q;
    assign DIG_SEL = dig_sel_q;
    assign FRAME   = frame_q;

`ifdef SEG7_BIN2BCD_EN

    localparam int unsigned CNT_W = $clog2(VW);

    function automatic logic [VW-1:0] pow10_f();
        logic [VW-1:0] p;
        p = VW'(1);
        for (int unsigned i = 0; i < NDIG; i++) begin
            p = p * VW'(10);
        end
        return p;
    endfunction

    localparam logic [VW-1:0] POW10 = pow10_f();

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [VW-1:0]    bin_q, bin_d;
    logic [VW-1:0]    bcd_q, bcd_d;
    logic [VW-1:0]    bcd_adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        shadow_d   = shadow_q;
        dots_d     = dots_q;

        // Double-dabble add-3 step; the top BCD digit may wrap on overflow,
        // which is harmless because overflow is flagged from the raw value.
        bcd_adj = bcd_q;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (LOAD) begin
                    bin_d      = VALUE;
                    dots_d     = DOTS;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (VALUE >= POW10);
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VW - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                shadow_d = bcd_q;
                ovf_d    = ovf_pend_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
        end
    end

    assign BUSY     = (state_q != ST_IDLE);
    assign ovf_show = ovf_q;

`else

    always_comb begin
        shadow_d = shadow_q;
        dots_d   = dots_q;
        if (LOAD) begin
            shadow_d = VALUE;
            dots_d   = DOTS;
        end
    end

    assign BUSY     = 1'b0;
    assign ovf_show = 1'b0;

`endif

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    localparam int unsigned NDIG       = 4;
    localparam int unsigned PRESC_LOG2 = 4;
    localparam int unsigned BRIGHT_W   = 4;
    localparam int unsigned SLOT       = 1 << PRESC_LOG2;
    localparam int unsigned CONV_BUSY  = 4 * NDIG + 1;

    logic                CLK = 1'b0;
    logic                RST_N;
    logic [4*NDIG-1:0]   VALUE;
    logic [NDIG-1:0]     DOTS;
    logic                LOAD;
    logic                BUSY;
    logic                BLANK_LZ;
    logic [BRIGHT_W-1:0] BRIGHT;
    logic [6:0]          SEG;
    logic                DP;
    logic [NDIG-1:0]     DIG_SEL;
    logic                FRAME;

    seg7_scan_ctrl #(
        .NDIG       (NDIG),
        .PRESC_LOG2 (PRESC_LOG2),
        .BRIGHT_W   (BRIGHT_W)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .VALUE    (VALUE),
        .DOTS     (DOTS),
        .LOAD     (LOAD),
        .BUSY     (BUSY),
        .BLANK_LZ (BLANK_LZ),
        .BRIGHT   (BRIGHT),
        .SEG      (SEG),
        .DP       (DP),
        .DIG_SEL  (DIG_SEL),
        .FRAME    (FRAME)
    );

    always #5 CLK = ~CLK;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: scan position derived from cycles since reset release
    int unsigned       n;
    logic [4*NDIG-1:0] m_shadow;
    logic [NDIG-1:0]   m_dots;
    bit                m_ovf;
    int unsigned       m_busy_left;
    logic [4*NDIG-1:0] m_pend;
    logic [6:0]        font_tab [16];

    int unsigned frame_seen;
    int unsigned en_seen;
    int unsigned busy_seen;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [4*NDIG-1:0] to_bcd(input logic [4*NDIG-1:0] v);
        logic [4*NDIG-1:0] r;
        longint unsigned   x;
        x = v;
        r = '0;
        for (int k = 0; k < int'(NDIG); k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic longint unsigned pow10(input int unsigned e);
        longint unsigned p = 1;
        for (int unsigned i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    task automatic model_reset();
        n           = 0;
        m_shadow    = '0;
        m_dots      = '0;
        m_ovf       = 0;
        m_busy_left = 0;
        m_pend      = '0;
    endtask

    task automatic rst_check(input string tag);
        chk({tag, "_seg"},   16'(SEG),     16'h7F);
        chk({tag, "_dp"},    16'(DP),      16'h1);
        chk({tag, "_dsel"},  16'(DIG_SEL), 16'h0);
        chk({tag, "_frame"}, 16'(FRAME),   16'h0);
        chk({tag, "_busy"},  16'(BUSY),    16'h0);
    endtask

    // One clock: predict the registered outputs from the state before the
    // edge and the inputs presented now, advance the model, then compare.
    task automatic step();
        int unsigned     presc, idx, phase;
        bit              en, blank;
        logic [NDIG-1:0] exp_dsel;
        logic [6:0]      exp_seg;
        logic            exp_dp, exp_frame, exp_busy;

        presc = n % SLOT;
        idx   = (NDIG - 1) - ((n / SLOT) % NDIG);
        phase = presc >> (PRESC_LOG2 - BRIGHT_W);
        en    = (presc != SLOT - 1) && ((BRIGHT == '1) || (phase < BRIGHT));
        exp_dsel = '0;
        if (en) exp_dsel[idx] = 1'b1;
        blank   = BLANK_LZ && (idx != 0) && ((m_shadow >> (4 * idx)) == 0);
        exp_seg = m_ovf ? 7'h3F : (blank ? 7'h7F : font_tab[m_shadow[4*idx +: 4]]);
        exp_dp  = ~m_dots[idx];
        exp_frame = (presc == SLOT - 1) && (idx == 0);

`ifdef SEG7_BIN2BCD_EN
        if (m_busy_left == 0) begin
            if (LOAD) begin
                m_pend      = VALUE;
                m_dots      = DOTS;
                m_busy_left = CONV_BUSY;
            end
        end else begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_shadow = to_bcd(m_pend);
                m_ovf    = (longint'(m_pend) >= pow10(NDIG));
            end
        end
`else
        if (LOAD) begin
            m_shadow = VALUE;
            m_dots   = DOTS;
        end
`endif
        exp_busy = (m_busy_left != 0);

        @(posedge CLK);
        #1;
        n++;
        chk("seg",     16'(SEG),     16'(exp_seg));
        chk("dp",      16'(DP),      16'(exp_dp));
        chk("dig_sel", 16'(DIG_SEL), 16'(exp_dsel));
        chk("frame",   16'(FRAME),   16'(exp_frame));
        chk("busy",    16'(BUSY),    16'(exp_busy));
        frame_seen += int'(FRAME);
        en_seen    += int'(|DIG_SEL);
        busy_seen  += int'(BUSY);
    endtask

    task automatic run(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) step();
    endtask

    task automatic load_pulse(input logic [4*NDIG-1:0] v, input logic [NDIG-1:0] d);
        VALUE = v;
        DOTS  = d;
        LOAD  = 1'b1;
        step();
        LOAD  = 1'b0;
    endtask

    task automatic reset_cycle(input string tag);
        RST_N = 1'b0;
        #1;
        rst_check(tag);
        repeat (2) begin
            @(posedge CLK);
            #1;
            rst_check(tag);
        end
        RST_N = 1'b1;
        model_reset();
    endtask

    initial begin
        font_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        RST_N    = 1'b0;
        VALUE    = 16'h12AF;
        DOTS     = '0;
        LOAD     = 1'b1;
        BLANK_LZ = 1'b0;
        BRIGHT   = '1;
        model_reset();

        // Reset hold with LOAD pending: outputs stay dark
        repeat (3) begin
            @(posedge CLK);
            #1;
            rst_check("reset_hold");
        end
        RST_N = 1'b1;

        // First capture of 12AF, then two full frames at full brightness
        load_pulse(16'h12AF, '0);
        frame_seen = 0;
        run(2 * NDIG * SLOT);
        chk("frames_in_128", 16'(frame_seen), 16'd2);

        // Brightness extremes
        BRIGHT  = '0;
        en_seen = 0;
        run(NDIG * SLOT);
        chk("bright0_on_cycles", 16'(en_seen), 16'd0);
        BRIGHT  = 4'd4;
        en_seen = 0;
        run(NDIG * SLOT);
        chk("bright4_on_cycles", 16'(en_seen), 16'(4 * NDIG));
        BRIGHT  = '1;
        en_seen = 0;
        run(NDIG * SLOT);
        chk("bright15_on_cycles", 16'(en_seen), 16'((SLOT - 1) * NDIG));

        // Leading-zero blanking with a dot on a blanked digit
        BLANK_LZ = 1'b1;
        load_pulse(16'h0070, 4'b1000);
        run(NDIG * SLOT + 24);
        load_pulse(16'h0000, 4'b0000);
        run(NDIG * SLOT);
        BLANK_LZ = 1'b0;
        run(SLOT);

        // Asynchronous reset in the middle of a slot
        load_pulse(16'h5A3C, 4'b0101);
        run(7);
        reset_cycle("reset_mid");
        run(NDIG * SLOT);

`ifdef SEG7_BIN2BCD_EN
        // LOAD held for 3 cycles: only the first capture counts
        VALUE = 16'd1234;
        DOTS  = 4'b0010;
        LOAD  = 1'b1;
        busy_seen = 0;
        step();
        VALUE = 16'd9999;
        step();
        step();
        LOAD = 1'b0;
        run(CONV_BUSY + 2);
        chk("busy_width", 16'(busy_seen), 16'(CONV_BUSY));
        run(NDIG * SLOT);

        // Overflow shows dashes everywhere, even with blanking on
        BLANK_LZ = 1'b1;
        load_pulse(16'd10000, 4'b0001);
        run(NDIG * SLOT + CONV_BUSY);
        load_pulse(16'd9999, 4'b0000);
        run(NDIG * SLOT + CONV_BUSY);

        // Reset during conversion aborts it
        load_pulse(16'd4321, 4'b1111);
        run(5);
        reset_cycle("reset_conv");
        run(NDIG * SLOT);
        load_pulse(16'd7, 4'b0000);
        run(NDIG * SLOT + CONV_BUSY);
        BLANK_LZ = 1'b0;
`endif

        // Randomized phases
        for (int unsigned it = 0; it < 30; it++) begin
            logic [4*NDIG-1:0] v;
            v = 16'($urandom);
            v = v & (16'hFFFF >> (4 * $urandom_range(0, 3)));
            BRIGHT   = 4'($urandom);
            BLANK_LZ = 1'($urandom);
            load_pulse(v, 4'($urandom));
            for (int unsigned c = 0; c < $urandom_range(10, 60); c++) begin
                LOAD  = ($urandom_range(0, 15) == 0);
                VALUE = 16'($urandom);
                DOTS  = 4'($urandom);
                step();
            end
            LOAD = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
